int_div: RTL

INT_DIV -- requirements
Module: int_div

---
 rtl/int_div_pkg.sv | 24 ++
 rtl/int_div_cseladd.sv | 24 ++
 rtl/int_div.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/int_div_pkg.sv
// Shared definitions for the 64-bit integer divider: data width, operation codes,
// controller states and the two's-complement negate helper.
package int_div_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        FN_DIV  = 2'b00,
        FN_DIVU = 2'b01,
        FN_REM  = 2'b10,
        FN_REMU = 2'b11
    } funct_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

endpackage

// File: rtl/int_div_cseladd.sv
// Carry-select adder: ripple low half, precompute the high half for both carries
// and pick one with the low-half carry out.
module cseladd #(
    parameter int W = 65
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0]   lo_sum;
    logic [HI-1:0] hi_sum0;
    logic [HI-1:0] hi_sum1;

    assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
    assign hi_sum0 = a[W-1:LO] + b[W-1:LO];
    assign hi_sum1 = a[W-1:LO] + b[W-1:LO] + {{(HI-1){1'b0}}, 1'b1};
    assign sum     = {(lo_sum[LO] ? hi_sum1 : hi_sum0), lo_sum[LO-1:0]};

endmodule

// File: rtl/int_div.sv
// Sequential 64-bit signed/unsigned divider: radix-2 restoring division, one quotient
// bit per cycle, with single-cycle bypass for divide-by-zero and signed overflow.
module int_div
    import int_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [1:0]      funct,
    input  logic            start,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] int_div_out
);

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            isrem_q, isrem_d;
    logic            fin_q, fin_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    funct_e          fn;
    logic            fn_signed, fn_rem;
    logic            op1_neg, op2_neg, div_zero, ovf;
    logic [XLEN-1:0] neg_in_a, neg_in_b, neg_a, neg_b;
    logic [XLEN:0]   trial;

    assign fn        = funct_e'(funct);
    assign fn_signed = (fn == FN_DIV) || (fn == FN_REM);
    assign fn_rem    = (fn == FN_REM) || (fn == FN_REMU);
    assign op1_neg   = fn_signed && op1[XLEN-1];
    assign op2_neg   = fn_signed && op2[XLEN-1];
    assign div_zero  = (op2 == '0);
    assign ovf       = fn_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

    // One negator pair: operands while latching, quotient/remainder while finishing.
    assign neg_in_a = (state_q == S_CALC) ? quo_q : op1;
    assign neg_in_b = (state_q == S_CALC) ? rem_q : op2;
    assign neg_a    = negate(neg_in_a);
    assign neg_b    = negate(neg_in_b);

    cseladd #(.W(XLEN + 1)) u_sub (
        .a   ({rem_q, quo_q[XLEN-1]}),
        .b   (~{1'b0, dvsr_q}),
        .cin (1'b1),
        .sum (trial)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        out_d   = out_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        isrem_d = isrem_q;
        fin_d   = fin_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = 6'd0;
                    isrem_d = fn_rem;
                    dvsr_d  = op2;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    // Bypass cases preload the final result and skip straight to finishing.
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = op1;
                        fin_d = 1'b1;
                    end else if (ovf) begin
                        quo_d = op1;
                        rem_d = '0;
                        fin_d = 1'b1;
                    end else begin
                        quo_d  = op1_neg ? neg_a : op1;
                        dvsr_d = op2_neg ? neg_b : op2;
                        rem_d  = '0;
                        qneg_d = op1_neg ^ op2_neg;
                        rneg_d = op1_neg;
                        fin_d  = 1'b0;
                    end
                end
            end
            S_CALC: begin
                if (fin_q) begin
                    if (isrem_q) out_d = rneg_q ? neg_b : rem_q;
                    else         out_d = qneg_q ? neg_a : quo_q;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    fin_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                    rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) fin_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            out_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            out_q   <= out_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            isrem_q <= isrem_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign busy        = busy_q;
    assign ready       = ready_q;
    assign int_div_out = out_q;

endmodule
